// File: rtl/cordic_hyp_rotate_if.sv
// rtl/cordic_hyp_rotate_if.sv - start/done handshake and result bundle for cordic_hyp_rotate (CORDIC_EXP_EN adds exp_out)
interface cordic_hyp_rotate_if;
    logic        start;
    logic [19:0] z_in;
    logic        busy;
    logic        done;
    logic [19:0] cosh_out;
    logic [19:0] sinh_out;
    logic        range_err;
`ifdef CORDIC_EXP_EN
    logic [19:0] exp_out;

    modport master (output start, z_in,
                    input  busy, done, cosh_out, sinh_out, range_err, exp_out);
    modport slave  (input  start, z_in,
                    output busy, done, cosh_out, sinh_out, range_err, exp_out);
`else
    modport master (output start, z_in,
                    input  busy, done, cosh_out, sinh_out, range_err);
    modport slave  (input  start, z_in,
                    output busy, done, cosh_out, sinh_out, range_err);
`endif
endinterface

// File: rtl/cordic_hyp_rotate.sv
// rtl/cordic_hyp_rotate.sv - iterative hyperbolic CORDIC rotation producing cosh/sinh; CORDIC_EXP_EN adds exp_out
module cordic_hyp_rotate #(
    parameter int          ITER   = 16,
    parameter logic [19:0] X_INIT = 20'h1351E
) (
    input  logic               clk,
    input  logic               rst,
    cordic_hyp_rotate_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic signed [19:0] Z_LIM    = 20'sh11E42;
    localparam logic [4:0]         LAST_IDX = 5'(ITER);

    state_t             state;
    logic signed [19:0] x, y, z;
    logic [4:0]         idx;
    logic               rep;

    logic signed [19:0] x_sh, y_sh, ang;
    logic signed [19:0] x_nx, y_nx, z_nx;
    logic               rep_idx, last_step;

    // atanh(2^-i) in Q3.16, truncated toward zero
    function automatic logic [19:0] atanh_rom(input logic [4:0] i);
        case (i)
            5'd1:    atanh_rom = 20'h08C9F;
            5'd2:    atanh_rom = 20'h04162;
            5'd3:    atanh_rom = 20'h0202B;
            5'd4:    atanh_rom = 20'h01005;
            5'd5:    atanh_rom = 20'h00800;
            5'd6:    atanh_rom = 20'h00400;
            5'd7:    atanh_rom = 20'h00200;
            5'd8:    atanh_rom = 20'h00100;
            5'd9:    atanh_rom = 20'h00080;
            5'd10:   atanh_rom = 20'h00040;
            5'd11:   atanh_rom = 20'h00020;
            5'd12:   atanh_rom = 20'h00010;
            5'd13:   atanh_rom = 20'h00008;
            5'd14:   atanh_rom = 20'h00004;
            5'd15:   atanh_rom = 20'h00002;
            5'd16:   atanh_rom = 20'h00001;
            default: atanh_rom = 20'h00000;
        endcase
    endfunction

    always_comb begin
        x_sh = x >>> idx;
        y_sh = y >>> idx;
        ang  = atanh_rom(idx);
        if (!z[19]) begin
            x_nx = x + y_sh;
            y_nx = y + x_sh;
            z_nx = z - ang;
        end else begin
            x_nx = x - y_sh;
            y_nx = y - x_sh;
            z_nx = z + ang;
        end
        rep_idx   = (idx == 5'd4) || (idx == 5'd13);
        // a repeated index is only final on its second pass
        last_step = (idx == LAST_IDX) && !(rep_idx && !rep);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            z             <= '0;
            idx           <= '0;
            rep           <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.range_err <= 1'b0;
            bus.cosh_out  <= '0;
            bus.sinh_out  <= '0;
`ifdef CORDIC_EXP_EN
            bus.exp_out   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        x             <= X_INIT;
                        y             <= '0;
                        z             <= bus.z_in;
                        idx           <= 5'd1;
                        rep           <= 1'b0;
                        bus.busy      <= 1'b1;
                        bus.range_err <= ($signed(bus.z_in) > Z_LIM) ||
                                         ($signed(bus.z_in) < -Z_LIM);
                        state         <= RUN;
                    end
                end
                RUN: begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    if (rep_idx && !rep) begin
                        rep <= 1'b1;
                    end else begin
                        rep <= 1'b0;
                        idx <= idx + 5'd1;
                    end
                    if (last_step) begin
                        bus.cosh_out <= x_nx;
                        bus.sinh_out <= y_nx;
`ifdef CORDIC_EXP_EN
                        bus.exp_out  <= x_nx + y_nx;
`endif
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_hyp_rotate.sv
// tb/tb_cordic_hyp_rotate.sv - self-checking bench for cordic_hyp_rotate (CORDIC_EXP_EN checks exp_out)
module tb_cordic_hyp_rotate;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cordic_hyp_rotate_if bus();

    cordic_hyp_rotate #(.ITER(16), .X_INIT(20'h1351E)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [19:0] z;
        int          cosh_v;
        int          sinh_v;
        int          exp_v;
        logic        rerr;
        int          tol;
    } vec_t;

    localparam int ZLIM = 73282;

    int n_pass  = 0;
    int n_total = 0;

    function automatic int s20(input logic [19:0] v);
        return int'($signed(v));
    endfunction

    function automatic int q16(input real r);
        return $rtoi(r * 65536.0 + ((r >= 0.0) ? 0.5 : -0.5));
    endfunction

    task automatic check_eq(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        int diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        n_total++;
        if (diff <= tol) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    endtask

    task automatic run_one(input logic [19:0] z, output int lat);
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.z_in = z;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   lat, cnt, first, second;
        int   zi;
        real  zr;
        logic [19:0] held;

        vecs[0] = '{z: 20'h00000, cosh_v: 'h10000, sinh_v: 0,         exp_v: 'h10000, rerr: 1'b0, tol: 4};
        vecs[1] = '{z: 20'h08000, cosh_v: 'h120AC, sinh_v: 'h08566,   exp_v: 'h1A612, rerr: 1'b0, tol: 4};
        vecs[2] = '{z: 20'hF8000, cosh_v: 'h120AC, sinh_v: -'h08566,  exp_v: 'h09B46, rerr: 1'b0, tol: 4};
        vecs[3] = '{z: 20'h18000, cosh_v: 0,       sinh_v: 0,         exp_v: 0,       rerr: 1'b1, tol: -1};
        vecs[4] = '{z: 20'h10000, cosh_v: 'h18B07, sinh_v: 'h12CD9,   exp_v: 'h2B7E1, rerr: 1'b0, tol: 6};

        bus.start = 1'b0;
        bus.z_in  = '0;
        rst       = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("reset_busy", int'(bus.busy), 0);
        check_eq("reset_done", int'(bus.done), 0);
        check_eq("reset_range_err", int'(bus.range_err), 0);
        check_eq("reset_cosh", s20(bus.cosh_out), 0);
        check_eq("reset_sinh", s20(bus.sinh_out), 0);

        for (int v = 0; v < 5; v++) begin
            run_one(vecs[v].z, lat);
            check_eq($sformatf("vec%0d_latency", v), lat, 18);
            check_eq($sformatf("vec%0d_range_err", v), int'(bus.range_err), int'(vecs[v].rerr));
            if (vecs[v].tol >= 0) begin
                check_near($sformatf("vec%0d_cosh", v), s20(bus.cosh_out), vecs[v].cosh_v, vecs[v].tol);
                check_near($sformatf("vec%0d_sinh", v), s20(bus.sinh_out), vecs[v].sinh_v, vecs[v].tol);
`ifdef CORDIC_EXP_EN
                check_near($sformatf("vec%0d_exp", v), s20(bus.exp_out), vecs[v].exp_v, vecs[v].tol + 2);
`endif
            end
        end

        // results must hold through idle cycles
        held = bus.cosh_out;
        repeat (6) @(posedge clk);
        #1 check_eq("hold_cosh", s20(bus.cosh_out), s20(held));
        check_eq("hold_busy_idle", int'(bus.busy), 0);

        // convergence-limit boundaries
        run_one(20'h11E42, lat);
        check_eq("lim_pos_in", int'(bus.range_err), 0);
        run_one(20'h11E43, lat);
        check_eq("lim_pos_out", int'(bus.range_err), 1);
        run_one(20'hEE1BE, lat);
        check_eq("lim_neg_in", int'(bus.range_err), 0);
        run_one(20'hEE1BD, lat);
        check_eq("lim_neg_out", int'(bus.range_err), 1);

        // randomized angles against real-valued hyperbolic functions
        for (int r = 0; r < 24; r++) begin
            zi = int'($urandom_range(0, 2 * ZLIM + 8000)) - ZLIM - 4000;
            run_one(20'(zi), lat);
            check_eq($sformatf("rnd%0d_latency", r), lat, 18);
            check_eq($sformatf("rnd%0d_range_err", r), int'(bus.range_err),
                     int'((zi > ZLIM) || (zi < -ZLIM)));
            if ((zi <= ZLIM) && (zi >= -ZLIM)) begin
                zr = real'(zi) / 65536.0;
                check_near($sformatf("rnd%0d_cosh z=%0d", r, zi), s20(bus.cosh_out),
                           q16(($exp(zr) + $exp(-zr)) / 2.0), 16);
                check_near($sformatf("rnd%0d_sinh z=%0d", r, zi), s20(bus.sinh_out),
                           q16(($exp(zr) - $exp(-zr)) / 2.0), 16);
`ifdef CORDIC_EXP_EN
                check_near($sformatf("rnd%0d_exp z=%0d", r, zi), s20(bus.exp_out), q16($exp(zr)), 24);
`endif
            end
        end

        // reset at RUN step 9 aborts without a done pulse
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.z_in = 20'h08000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("abort_busy", int'(bus.busy), 0);
        check_eq("abort_cosh_cleared", s20(bus.cosh_out), 0);
        cnt = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1 if (bus.done) cnt++;
        end
        check_eq("abort_no_done", cnt, 0);
        run_one(20'h00000, lat);
        check_eq("after_abort_latency", lat, 18);
        check_near("after_abort_cosh", s20(bus.cosh_out), 'h10000, 4);

        // a start pulse while busy is ignored
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.z_in = 20'h08000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.start = 1'b1;
        bus.z_in = 20'h18000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cnt = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1 if (bus.done) cnt++;
        end
        check_eq("busy_start_one_done", cnt, 1);
        check_eq("busy_start_range_err", int'(bus.range_err), 0);
        check_near("busy_start_cosh", s20(bus.cosh_out), 'h120AC, 4);

        // start held high restarts every 20 edges
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.z_in = 20'h08000;
        cnt = 0;
        first = -1;
        second = -1;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                cnt++;
                if (first < 0) first = e;
                else if (second < 0) second = e;
            end
        end
        bus.start = 1'b0;
        check_eq("held_start_done_count", cnt, 2);
        check_eq("held_start_first", first, 19);
        check_eq("held_start_period", second - first, 20);
        cnt = 0;
        while (bus.busy && cnt < 30) begin
            @(posedge clk);
            #1 cnt++;
        end
        check_eq("held_start_drains", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
